// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryakbhyam multiplier with valid/ready flow control.
// Define VEDIC_MULT_ACC_EN to add the acc_clr input and the product accumulator.
module vedic_mult_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_MULT_ACC_EN
   input  logic               acc_clr,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             neg;
      logic             clr;
      logic [TAG_W-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] q0;
      logic [WIDTH-1:0] q1;
      logic [WIDTH-1:0] q2;
      logic [WIDTH-1:0] q3;
      logic             neg;
      logic             clr;
      logic [TAG_W-1:0] tag;
   } s2_t;

   // Magnitude of the most negative value wraps back to itself, which is its
   // correct unsigned magnitude, so no extra bit is needed.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s & x[WIDTH-1]) ? (~x) + WIDTH'(1) : x;
   endfunction

   logic [3:1]    vld_pipe;
   logic          adv;
   logic          in_clr;
   s1_t           s1;
   s2_t           s2;
   logic [PW-1:0] prod3;
   logic [PW-1:0] mid;
   logic [PW-1:0] sum;
   logic [PW-1:0] prod;
   logic          clr3;
   logic [TAG_W-1:0] tag3;

`ifdef VEDIC_MULT_ACC_EN
   assign in_clr = acc_clr;
`else
   assign in_clr = 1'b0;
`endif

   assign adv       = !vld_pipe[3] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[3];
   assign out_tag   = tag3;

   // Cross-product merge: middle terms land at H, the high term at WIDTH.
   assign mid  = PW'(s2.q1) + PW'(s2.q2);
   assign sum  = PW'(s2.q0) + (mid << H) + (PW'(s2.q3) << WIDTH);
   assign prod = s2.neg ? PW'(0) - sum : sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
         prod3    <= '0;
         clr3     <= 1'b0;
         tag3     <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[2:1], in_valid};
         s1.a     <= mag(in_a, in_signed);
         s1.b     <= mag(in_b, in_signed);
         s1.neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
         s1.clr   <= in_clr;
         s1.tag   <= in_tag;
         s2.q0    <= WIDTH'(s1.a[H-1:0])     * WIDTH'(s1.b[H-1:0]);
         s2.q1    <= WIDTH'(s1.a[WIDTH-1:H]) * WIDTH'(s1.b[H-1:0]);
         s2.q2    <= WIDTH'(s1.a[H-1:0])     * WIDTH'(s1.b[WIDTH-1:H]);
         s2.q3    <= WIDTH'(s1.a[WIDTH-1:H]) * WIDTH'(s1.b[WIDTH-1:H]);
         s2.neg   <= s1.neg;
         s2.clr   <= s1.clr;
         s2.tag   <= s1.tag;
         prod3    <= prod;
         clr3     <= s2.clr;
         tag3     <= s2.tag;
      end
   end

`ifdef VEDIC_MULT_ACC_EN
   logic [PW-1:0] acc;

   // Result presents the would-be ACC value; it is committed only on transfer.
   assign out_p = (clr3 ? PW'(0) : acc) + prod3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (vld_pipe[3] && out_ready)
         acc <= out_p;
   end
`else
   assign out_p = prod3;

   logic unused_clr;
   assign unused_clr = clr3;
`endif

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed-vector and stream bench for vedic_mult_pipe (WIDTH=32, TAG_W=4).
module tb_vedic_mult_pipe;
   localparam int W = 32;
   localparam int T = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_signed = 1'b0;
   logic [T-1:0]  in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [2*W-1:0] out_p;
   logic [T-1:0]  out_tag;
`ifdef VEDIC_MULT_ACC_EN
   logic          acc_clr = 1'b1;
`endif

   always #5 clk = ~clk;

   vedic_mult_pipe #(.WIDTH(W), .TAG_W(T)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
`ifdef VEDIC_MULT_ACC_EN
      .acc_clr(acc_clr),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
   );

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic [T-1:0]   tag;
      logic           clr;
      logic [2*W-1:0] exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[10];
   vec_t opq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [3:0] tag, input logic clr);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.tag = tag; v.clr = clr;
      v.exp = ref_mul(a, b, s);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      in_a = v.a; in_b = v.b; in_signed = v.s; in_tag = v.tag;
`ifdef VEDIC_MULT_ACC_EN
      acc_clr = v.clr;
`endif
   endtask

   // Streams opq through the DUT with an optional out_ready stall window,
   // scoring each delivered result against an in-order expectation queue.
   task automatic run_stream(input int stall_at, input int stall_len, input bit chk_rate);
      int   ni = 0, no = 0, cyc = 0, first = -1, last = -1;
      bit   holding = 0, saw_block = 0;
      logic [63:0] held_p, e_p, macc = '0;
      logic [3:0]  held_t;
      vec_t pend[$];
      vec_t e;
      while (no < opq.size() && cyc < 20000) begin
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         if (ni < opq.size()) begin
            in_valid = 1'b1;
            drive(opq[ni]);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (holding) begin
            chk("stall_hold_p", out_p, held_p);
            chk("stall_hold_tag", 64'(out_tag), 64'(held_t));
         end
         holding = 0;
         if (in_valid && !in_ready) saw_block = 1;
         if (out_valid && out_ready) begin
            if (pend.size() == 0) begin
               chk("stream_spurious", 64'(1), 64'(0));
            end else begin
               e = pend.pop_front();
               e_p = e.exp;
`ifdef VEDIC_MULT_ACC_EN
               macc = (e.clr ? 64'(0) : macc) + e.exp;
               e_p = macc;
`endif
               chk("stream_p", out_p, e_p);
               chk("stream_tag", 64'(out_tag), 64'(e.tag));
            end
            if (first < 0) first = cyc;
            last = cyc;
            no++;
         end else if (out_valid) begin
            held_p = out_p;
            held_t = out_tag;
            holding = 1;
         end
         if (in_valid && in_ready) begin
            pend.push_back(opq[ni]);
            ni++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", 64'(no), 64'(opq.size()));
      if (chk_rate) chk("stream_rate", 64'(last - first), 64'(opq.size() - 1));
      if (stall_len > 0) chk("stall_in_ready_low", 64'(saw_block), 64'(1));
   endtask

   initial begin
      int  lat;
      bit  seen;
      tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd3,  1'b1, 64'hFFFFFFFE00000001};
      tbl[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 4'd1,  1'b1, 64'hFFFFFFFFFFFFFFF1};
      tbl[2] = '{32'h80000000, 32'h80000000, 1'b1, 4'd2,  1'b1, 64'h4000000000000000};
      tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd4,  1'b1, 64'h0000000000000001};
      tbl[4] = '{32'h80000000, 32'h00000002, 1'b0, 4'd5,  1'b1, 64'h0000000100000000};
      tbl[5] = '{32'h00000000, 32'h12345678, 1'b1, 4'd6,  1'b1, 64'h0000000000000000};
      tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 4'd7,  1'b1, 64'hFFFFFFFF80000000};
      tbl[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 4'd8,  1'b1, 64'h3FFFFFFF00000001};
      tbl[8] = '{32'h12345678, 32'hFFFFFFFF, 1'b1, 4'd9,  1'b1, 64'hFFFFFFFFEDCBA988};
      tbl[9] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 4'd10, 1'b1, 64'h00000001FFFFFFFE};

      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_p", out_p, 64'(0));
      chk("rst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      // Single-op vectors: latency and value
      foreach (tbl[i]) begin
         in_valid = 1'b1;
         drive(tbl[i]);
         @(negedge clk);
         chk("vec_in_ready", 64'(in_ready), 64'(1));
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("vec_latency", 64'(lat), 64'(3));
         chk("vec_p", out_p, tbl[i].exp);
         chk("vec_tag", 64'(out_tag), 64'(tbl[i].tag));
         @(posedge clk); #1;
      end

      // Eight back-to-back ops, full rate
      opq.delete();
      for (int i = 0; i < 8; i++) opq.push_back(mk(32'(i * 1000 + 1), 32'(i + 2), 1'b0, 4'(i), 1'b1));
      run_stream(1000, 0, 1'b1);

      // Five-cycle output stall mid-stream
      opq.delete();
      for (int i = 0; i < 12; i++) opq.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i), 1'b1));
      run_stream(4, 5, 1'b0);

      // Random soak against the reference model
      opq.delete();
      for (int i = 0; i < 2000; i++) opq.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'b1));
      run_stream(100000, 0, 1'b1);

      // Reset with three ops in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         drive(mk(32'(i + 3), 32'(7), 1'b0, 4'(i), 1'b1));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("inflight_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(out_valid), 64'(0));
      chk("rst_mid_p", out_p, 64'(0));
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("rst_no_ghost", 64'(seen), 64'(0));

`ifdef VEDIC_MULT_ACC_EN
      opq.delete();
      opq.push_back(mk(32'd2, 32'd3, 1'b0, 4'd0, 1'b1));
      opq.push_back(mk(32'd4, 32'd5, 1'b0, 4'd1, 1'b0));
      opq.push_back(mk(32'hFFFFFFFF, 32'd1, 1'b1, 4'd2, 1'b0));
      opq.push_back(mk(32'd7, 32'd1, 1'b0, 4'd3, 1'b1));
      run_stream(2, 4, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
